// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver and baud tick.
// Holds the receiver FSM encoding, default line settings and the divider helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
    localparam int unsigned DEF_BAUD       = 115_200;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Clock cycles per oversample tick, rounded down.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing one-cycle ticks at BAUD*OVERSAMPLE.
// Never resynchronised to line activity, so receiver and transmitter can share it.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CW  = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled UART receiver, 8N1 LSB-first by default.
// Mid-bit sampling, start-bit glitch rejection and stop-bit framing check.
// Define UART_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rx_done,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  busy
);

    localparam int unsigned SW = cnt_width(OVERSAMPLE);
    localparam int unsigned BW = cnt_width(DATA_WIDTH);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    logic                  r_rx_meta, r_rx_s;
    rx_state_t             r_state, w_state_nxt;
    logic [SW-1:0]         r_s_cnt, w_s_cnt_nxt;
    logic [BW-1:0]         r_b_cnt, w_b_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [DATA_WIDTH-1:0] r_dout, w_dout_nxt;
    logic                  r_rx_done, w_rx_done_nxt;
    logic                  r_frame_err, w_frame_err_nxt;
    logic                  w_tick;
`ifdef UART_PARITY_EN
    logic                  r_par_bit, w_par_bit_nxt;
    logic                  r_parity_err, w_parity_err_nxt;
`endif

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Two-flop synchronizer; resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking so each stage takes the pre-edge value; blocking would merge the two stages.
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // FSM state, counters, shift register and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_s_cnt     <= '0;
            r_b_cnt     <= '0;
            r_shift     <= '0;
            r_dout      <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_s_cnt     <= w_s_cnt_nxt;
            r_b_cnt     <= w_b_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_dout      <= w_dout_nxt;
            r_rx_done   <= w_rx_done_nxt;
            r_frame_err <= w_frame_err_nxt;
`ifdef UART_PARITY_EN
            r_par_bit    <= w_par_bit_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    // Next-state logic: sample at mid start bit, then once per bit period.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_nxt     = r_state;
        w_s_cnt_nxt     = r_s_cnt;
        w_b_cnt_nxt     = r_b_cnt;
        w_shift_nxt     = r_shift;
        w_dout_nxt      = r_dout;
        w_rx_done_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
`ifdef UART_PARITY_EN
        w_par_bit_nxt    = r_par_bit;
        w_parity_err_nxt = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = START;
                    w_s_cnt_nxt = '0;
                end
            end

            START: begin
                if (w_tick) begin
                    if (r_s_cnt == S_MID) begin
                        w_s_cnt_nxt = '0;
                        w_b_cnt_nxt = '0;
                        // Line back high at mid start bit means a glitch, not a frame.
                        w_state_nxt = r_rx_s ? IDLE : DATA;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (w_tick) begin
                    if (r_s_cnt == S_LAST) begin
                        w_s_cnt_nxt = '0;
                        w_shift_nxt = {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                        if (r_b_cnt == B_LAST) begin
                            w_b_cnt_nxt = '0;
`ifdef UART_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end else begin
                            w_b_cnt_nxt = r_b_cnt + 1'b1;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 1'b1;
                    end
                end
            end

`ifdef UART_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    if (r_s_cnt == S_LAST) begin
                        w_s_cnt_nxt   = '0;
                        w_par_bit_nxt = r_rx_s;
                        w_state_nxt   = STOP;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 1'b1;
                    end
                end
            end
`endif

            STOP: begin
                if (w_tick) begin
                    if (r_s_cnt == S_LAST) begin
                        // Leaving at mid stop bit keeps half a bit to catch a back-to-back start.
                        w_s_cnt_nxt = '0;
                        w_state_nxt = IDLE;
                        if (!r_rx_s) begin
                            w_frame_err_nxt = 1'b1;
`ifdef UART_PARITY_EN
                        end else if (r_par_bit != ^r_shift) begin
                            w_parity_err_nxt = 1'b1;
`endif
                        end else begin
                            w_dout_nxt    = r_shift;
                            w_rx_done_nxt = 1'b1;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_s_cnt_nxt = '0;
            end
        endcase
    end

    assign dout      = r_dout;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);
`ifdef UART_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: self-checking bench for uart_rx_oversampled.
// Line rate raised to 625 kbit/s so the divider is exact (DIV=10) and the run stays short.
// Define UART_PARITY_EN for both bench and RTL to cover the parity build.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int unsigned CLK_FREQ   = 100_000_000;
    localparam int unsigned BAUD       = 625_000;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int BIT_NS  = 1_000_000_000 / BAUD;
    localparam int BIT_CYC = BIT_NS / 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] dout;
    logic       rx_done, frame_err, parity_err, busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_oversampled #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dout       (dout),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    logic [7:0] got [256];
    int      n_done = 0, n_fe = 0, n_pe = 0, n_both = 0, n_busy = 0;
    realtime t_done = 0, t_fall = 0;
    logic    busy_q = 1'b0;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            got[n_done % 256] = dout;
            n_done++;
            t_done = $realtime;
        end
        if (frame_err === 1'b1) n_fe++;
        if (parity_err === 1'b1) n_pe++;
        if (rx_done === 1'b1 && (frame_err === 1'b1 || parity_err === 1'b1)) n_both++;
        if (busy === 1'b1) n_busy++;
        if (busy_q === 1'b1 && busy === 1'b0) t_fall = $realtime;
        busy_q = busy;
    end

    // Reference model: what a correct receiver must deliver for each frame sent.
    logic [7:0] exp_q [$];
    int         exp_fe = 0, exp_pe = 0;

    task automatic send_bit(input logic b);
        rx = b;
        #(BIT_NS);
    endtask

    // A bad stop bit is held low across its middle and released after 3/4 bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        int ones;
        bit parity_good;
`ifdef UART_PARITY_EN
        logic pbit;
`endif
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
        pbit = ((ones % 2) == 1) ? par_ok : !par_ok;
        send_bit(pbit);
        ones += int'(pbit);
        parity_good = ((ones % 2) == 0);
`else
        parity_good = par_ok | 1'b1;
`endif
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            rx = 1'b0;
            #(BIT_NS * 3 / 4);
            rx = 1'b1;
            #(BIT_NS - BIT_NS * 3 / 4);
        end
        if (!stop_ok) exp_fe++;
        else if (!parity_good) exp_pe++;
        else exp_q.push_back(d);
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 4 * BIT_CYC) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", tag, busy, cyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        #23;
        n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else n_pass++;
        n_checks++; if (rx_done !== 1'b0) $display("FAIL reset_rx_done: got %b expected 0", rx_done); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else n_pass++;
        n_checks++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b expected 0", parity_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        @(posedge clk); #2; rst = 1'b1;
        #(2 * BIT_NS);
    endtask

    task automatic test_single();
        int b_done, b_fe;
        bit fall_ok;
        b_done = n_done; b_fe = n_fe;
        send_frame(8'h12, 1'b1, 1'b1);
        wait_idle("single");
        n_checks++; if (n_done - b_done !== 1) $display("FAIL single_count: got %0d expected 1", n_done - b_done); else n_pass++;
        n_checks++; if (got[b_done % 256] !== 8'h12) $display("FAIL single_byte: got %h expected 12", got[b_done % 256]); else n_pass++;
        n_checks++; if (dout !== 8'h12) $display("FAIL single_dout: got %h expected 12", dout); else n_pass++;
        n_checks++; if (n_fe - b_fe !== 0) $display("FAIL single_frame_err: got %0d expected 0", n_fe - b_fe); else n_pass++;
        fall_ok = (t_fall >= t_done) && (t_fall - t_done <= BIT_NS);
        n_checks++; if (fall_ok !== 1'b1) $display("FAIL single_busy_fall: done at %0t busy low at %0t, expected within %0d ns", t_done, t_fall, BIT_NS); else n_pass++;
        #(BIT_NS);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        int b_done, b_fe;
        seq[0] = 8'hAA; seq[1] = 8'hBB; seq[2] = 8'hCC; seq[3] = 8'h1B;
        b_done = n_done; b_fe = n_fe;
        for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1, 1'b1);
        wait_idle("b2b");
        n_checks++; if (n_done - b_done !== 4) $display("FAIL b2b_count: got %0d expected 4", n_done - b_done); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[(b_done + i) % 256] !== seq[i]) $display("FAIL b2b_byte%0d: got %h expected %h", i, got[(b_done + i) % 256], seq[i]);
            else n_pass++;
        end
        n_checks++; if (n_fe - b_fe !== 0) $display("FAIL b2b_frame_err: got %0d expected 0", n_fe - b_fe); else n_pass++;
        #(BIT_NS);
    endtask

    task automatic test_glitch();
        int b_done, b_fe, b_busy;
        b_done = n_done; b_fe = n_fe; b_busy = n_busy;
        rx = 1'b0;
        #(BIT_NS / 4);
        rx = 1'b1;
        #(2 * BIT_NS);
        n_checks++; if (!(n_busy > b_busy)) $display("FAIL glitch_busy_pulse: busy cycles %0d expected >0", n_busy - b_busy); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", busy); else n_pass++;
        n_checks++; if (n_done - b_done !== 0) $display("FAIL glitch_rx_done: got %0d expected 0", n_done - b_done); else n_pass++;
        n_checks++; if (n_fe - b_fe !== 0) $display("FAIL glitch_frame_err: got %0d expected 0", n_fe - b_fe); else n_pass++;
        n_checks++; if (dout !== 8'h1B) $display("FAIL glitch_dout: got %h expected 1b", dout); else n_pass++;
    endtask

    task automatic test_frame_err();
        int b_done, b_fe;
        b_done = n_done; b_fe = n_fe;
        send_frame(8'h55, 1'b0, 1'b1);
        send_bit(1'b1);
        wait_idle("ferr");
        n_checks++; if (n_fe - b_fe !== 1) $display("FAIL ferr_count: got %0d expected 1", n_fe - b_fe); else n_pass++;
        n_checks++; if (n_done - b_done !== 0) $display("FAIL ferr_rx_done: got %0d expected 0", n_done - b_done); else n_pass++;
        n_checks++; if (dout !== 8'h1B) $display("FAIL ferr_dout_held: got %h expected 1b", dout); else n_pass++;
        b_done = n_done;
        send_frame(8'h11, 1'b1, 1'b1);
        wait_idle("ferr_next");
        n_checks++; if (n_done - b_done !== 1) $display("FAIL ferr_next_count: got %0d expected 1", n_done - b_done); else n_pass++;
        n_checks++; if (dout !== 8'h11) $display("FAIL ferr_next_dout: got %h expected 11", dout); else n_pass++;
        #(BIT_NS);
    endtask

    task automatic test_reset_mid();
        int b_done;
        b_done = n_done;
        // 0xCC LSB first: 0,0,1,1,... ; reset lands in the middle of bit 3.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        #(BIT_NS / 2);
        n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy); else n_pass++;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_checks++; if (dout !== 8'h00) $display("FAIL rstmid_dout: got %h expected 00", dout); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if ({rx_done, frame_err, parity_err} !== 3'b000) $display("FAIL rstmid_pulses: got %b expected 000", {rx_done, frame_err, parity_err}); else n_pass++;
        #49;
        rst = 1'b1;
        #(3 * BIT_NS);
        n_checks++; if (n_done - b_done !== 0) $display("FAIL rstmid_discard: got %0d rx_done expected 0", n_done - b_done); else n_pass++;
        send_frame(8'h13, 1'b1, 1'b1);
        wait_idle("rstmid");
        n_checks++; if (n_done - b_done !== 1) $display("FAIL rstmid_next_count: got %0d expected 1", n_done - b_done); else n_pass++;
        n_checks++; if (dout !== 8'h13) $display("FAIL rstmid_next_dout: got %h expected 13", dout); else n_pass++;
        #(BIT_NS);
    endtask

    task automatic test_random();
        int b_done, b_fe, b_pe, n_exp;
        logic [7:0] d;
        bit stop_ok, par_ok;
        exp_q.delete();
        exp_fe = 0; exp_pe = 0;
        b_done = n_done; b_fe = n_fe; b_pe = n_pe;
        for (int i = 0; i < 12; i++) begin
            d       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 4) != 0);
`ifdef UART_PARITY_EN
            par_ok  = ($urandom_range(0, 3) != 0);
`else
            par_ok  = 1'b1;
`endif
            send_frame(d, stop_ok, par_ok);
            if (!stop_ok) send_bit(1'b1);
            repeat ($urandom_range(0, 2)) send_bit(1'b1);
        end
        wait_idle("rand");
        n_exp = exp_q.size();
        n_checks++; if (n_done - b_done !== n_exp) $display("FAIL rand_count: got %0d expected %0d", n_done - b_done, n_exp); else n_pass++;
        for (int i = 0; i < n_exp; i++) begin
            n_checks++;
            if (got[(b_done + i) % 256] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h expected %h", i, got[(b_done + i) % 256], exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (n_fe - b_fe !== exp_fe) $display("FAIL rand_frame_err: got %0d expected %0d", n_fe - b_fe, exp_fe); else n_pass++;
        n_checks++; if (n_pe - b_pe !== exp_pe) $display("FAIL rand_parity_err: got %0d expected %0d", n_pe - b_pe, exp_pe); else n_pass++;
        #(BIT_NS);
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int b_done, b_fe, b_pe;
        b_done = n_done; b_pe = n_pe;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_idle("par_ok");
        n_checks++; if (n_done - b_done !== 1) $display("FAIL par_ok_count: got %0d expected 1", n_done - b_done); else n_pass++;
        n_checks++; if (dout !== 8'h07) $display("FAIL par_ok_dout: got %h expected 07", dout); else n_pass++;
        b_done = n_done;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_idle("par_bad");
        n_checks++; if (n_pe - b_pe !== 1) $display("FAIL par_bad_count: got %0d expected 1", n_pe - b_pe); else n_pass++;
        n_checks++; if (n_done - b_done !== 0) $display("FAIL par_bad_rx_done: got %0d expected 0", n_done - b_done); else n_pass++;
        b_fe = n_fe; b_pe = n_pe;
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b1);
        wait_idle("par_both");
        n_checks++; if (n_fe - b_fe !== 1) $display("FAIL par_both_frame_err: got %0d expected 1", n_fe - b_fe); else n_pass++;
        n_checks++; if (n_pe - b_pe !== 0) $display("FAIL par_both_parity_err: got %0d expected 0", n_pe - b_pe); else n_pass++;
        #(BIT_NS);
    endtask
`endif

    task automatic test_exclusive();
        n_checks++; if (n_both !== 0) $display("FAIL exclusive_pulses: %0d cycles with rx_done and an error together, expected 0", n_both); else n_pass++;
`ifndef UART_PARITY_EN
        n_checks++; if (n_pe !== 0) $display("FAIL parity_err_tied: got %0d pulses expected 0", n_pe); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_random();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
